// File: rtl/chan_scan_mux_if.sv
// Signal bundle for chan_scan_mux: control/data inputs from the capture side,
// tagged sample outputs towards the compare stage.
interface chan_scan_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
);
  logic                      en;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS-1:0]       ch_mask;
  logic [CHANNELS*WIDTH-1:0] ch_data;
  logic [WIDTH-1:0]          y;
  logic [SEL_W-1:0]          y_ch;
  logic                      y_valid;
  logic                      scan_done;

  modport master (
    output en, mode, sel, ch_mask, ch_data,
    input  y, y_ch, y_valid, scan_done
  );

  modport slave (
    input  en, mode, sel, ch_mask, ch_data,
    output y, y_ch, y_valid, scan_done
  );
endinterface

// File: rtl/chan_scan_mux.sv
// Registered N-channel selector: manual select or round-robin auto-scan over
// the channels enabled in ch_mask, with a fixed dwell per channel.
module chan_scan_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 4
) (
  input  logic           clk,
  input  logic           rst,
  chan_scan_mux_if.slave bus
);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic {S_MAN, S_SCAN} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [SEL_W-1:0] y_ch_q, y_ch_d;
  logic             y_valid_q, y_valid_d;
  logic             scan_done_q, scan_done_d;
  logic [SEL_W-1:0] cur_ptr;

  logic [WIDTH-1:0] ch_word [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign ch_word[gi] = bus.ch_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // First set bit of m at circular offset >= first_off from 'from'; 'from' if none.
  function automatic logic [SEL_W-1:0] find_set(input logic [CHANNELS-1:0] m,
                                                input logic [SEL_W-1:0] from,
                                                input int first_off);
    logic [SEL_W-1:0] r;
    logic             hit;
    int               idx;
    r   = from;
    hit = 1'b0;
    for (int k = 0; k <= CHANNELS; k++) begin
      idx = (int'(from) + k) % CHANNELS;
      if (!hit && k >= first_off && m[idx]) begin
        r   = SEL_W'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [SEL_W-1:0] highest_set(input logic [CHANNELS-1:0] m);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (m[i]) r = SEL_W'(i);
    end
    return r;
  endfunction

  always_comb begin
    state_d     = bus.mode ? S_SCAN : S_MAN;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    y_d         = y_q;
    y_ch_d      = y_ch_q;
    y_valid_d   = 1'b0;
    scan_done_d = 1'b0;
    cur_ptr     = ptr_q;

    if (!bus.mode) begin
      if (bus.en && int'(bus.sel) < CHANNELS) begin
        y_d       = ch_word[bus.sel];
        y_ch_d    = bus.sel;
        y_valid_d = 1'b1;
      end else begin
        y_d = '0;
      end
    end else if (state_q == S_MAN) begin
      ptr_d = find_set(bus.ch_mask, '0, 0);
      cnt_d = '0;
      if (!bus.en) y_d = '0;
    end else if (!bus.en || bus.ch_mask == '0) begin
      y_d = '0;
    end else begin
      // A dwell that starts on a disabled channel (mask was empty or changed
      // between dwells) is realigned to the next enabled channel.
      if (cnt_q == '0 && !bus.ch_mask[ptr_q]) begin
        cur_ptr = find_set(bus.ch_mask, ptr_q, 0);
      end
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        ptr_d = find_set(bus.ch_mask, cur_ptr, 1);
        if (bus.ch_mask[cur_ptr]) begin
          y_d         = ch_word[cur_ptr];
          y_ch_d      = cur_ptr;
          y_valid_d   = 1'b1;
          scan_done_d = (cur_ptr == highest_set(bus.ch_mask));
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        ptr_d = cur_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_MAN;
      ptr_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      y_ch_q      <= '0;
      y_valid_q   <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      y_q         <= y_d;
      y_ch_q      <= y_ch_d;
      y_valid_q   <= y_valid_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.y_ch      = y_ch_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.scan_done = scan_done_q;
endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: one DUT with DWELL=4, one with DWELL=1.
module tb_chan_scan_mux;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam logic [N*W-1:0] DATA = 32'h4433_2211;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  chan_scan_mux_if #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) a_if ();
  chan_scan_mux_if #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW)) b_if ();

  chan_scan_mux #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW), .DWELL(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  chan_scan_mux #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW), .DWELL(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] word_of(input int ch);
    return 8'((ch + 1) * 8'h11);
  endfunction

  task automatic check_quiet(input string tag);
    check_val({tag, "_valid"}, 32'(a_if.y_valid), 32'd0);
    check_val({tag, "_done"},  32'(a_if.scan_done), 32'd0);
  endtask

  task automatic check_sample(input string tag, input int ch, input logic [7:0] yv, input logic done);
    check_val({tag, "_valid"}, 32'(a_if.y_valid), 32'd1);
    check_val({tag, "_ch"},    32'(a_if.y_ch), 32'(ch));
    check_val({tag, "_y"},     32'(a_if.y), 32'(yv));
    check_val({tag, "_done"},  32'(a_if.scan_done), 32'(done));
  endtask

  // Return A to manual, then enter auto: after this the first scan cycle begins.
  task automatic enter_auto(input logic [3:0] mask);
    a_if.mode = 1'b0; a_if.en = 1'b0;
    tick();
    a_if.ch_mask = mask; a_if.mode = 1'b1; a_if.en = 1'b1;
    tick();
    check_quiet("entry");
  endtask

  initial begin
    rst = 1'b1;
    a_if.en = 1'b0; a_if.mode = 1'b0; a_if.sel = '0; a_if.ch_mask = '0; a_if.ch_data = DATA;
    b_if.en = 1'b0; b_if.mode = 1'b0; b_if.sel = '0; b_if.ch_mask = '0; b_if.ch_data = DATA;
    tick();
    tick();
    check_val("rst_y", 32'(a_if.y), 32'd0);
    check_val("rst_ch", 32'(a_if.y_ch), 32'd0);
    check_quiet("rst");
    rst = 1'b0;

    // Manual mode
    a_if.en = 1'b1; a_if.sel = 2'd2;
    tick();
    check_sample("man_sel2", 2, 8'h33, 1'b0);
    a_if.sel = 2'd3;
    tick();
    check_sample("man_sel3", 3, 8'h44, 1'b0);
    a_if.en = 1'b0;
    tick();
    check_val("man_off_y", 32'(a_if.y), 32'd0);
    check_val("man_off_ch", 32'(a_if.y_ch), 32'd3);
    check_quiet("man_off");

    // Full mask, DWELL=4: samples at 4,8,12,16,20
    enter_auto(4'b1111);
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c % 4 == 0)
        check_sample($sformatf("scan_c%0d", c), (c/4 - 1) % 4, word_of((c/4 - 1) % 4), c == 16);
      else
        check_quiet($sformatf("scan_c%0d", c));
    end

    // en stall for 3 cycles at cnt=2 of channel 1
    enter_auto(4'b1111);
    for (int c = 1; c <= 11; c++) begin
      a_if.en = (c >= 7 && c <= 9) ? 1'b0 : 1'b1;
      tick();
      if (c == 4)       check_sample("stall_ch0", 0, 8'h11, 1'b0);
      else if (c == 11) check_sample("stall_ch1", 1, 8'h22, 1'b0);
      else              check_quiet($sformatf("stall_c%0d", c));
      if (c >= 7 && c <= 9) check_val($sformatf("stall_y_c%0d", c), 32'(a_if.y), 32'd0);
    end

    // Empty mask, then a single channel
    enter_auto(4'b0000);
    for (int c = 1; c <= 10; c++) begin
      tick();
      check_quiet($sformatf("empty_c%0d", c));
    end
    a_if.ch_mask = 4'b0100;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c % 4 == 0) check_sample($sformatf("single_c%0d", c), 2, 8'h33, 1'b1);
      else            check_quiet($sformatf("single_c%0d", c));
    end

    // Channel 0 disabled mid-dwell: its sample is dropped, channel 1 follows
    enter_auto(4'b1111);
    for (int c = 1; c <= 8; c++) begin
      if (c == 3) a_if.ch_mask = 4'b1110;
      tick();
      if (c == 8) check_sample("middwell_ch1", 1, 8'h22, 1'b0);
      else        check_quiet($sformatf("middwell_c%0d", c));
    end

    // Reset at cnt=2 on channel 2, mode held; sample reflects data at the edge
    enter_auto(4'b1111);
    for (int c = 1; c <= 10; c++) tick();
    check_val("pre_rst_y", 32'(a_if.y), 32'h22);
    rst = 1'b1;
    tick();
    check_val("mid_rst_y", 32'(a_if.y), 32'd0);
    check_val("mid_rst_ch", 32'(a_if.y_ch), 32'd0);
    check_quiet("mid_rst");
    rst = 1'b0;
    tick();
    check_quiet("rst_entry");
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) a_if.ch_data = {DATA[31:8], 8'h5A};
      tick();
      if (c == 4) check_sample("rst_restart", 0, 8'h5A, 1'b0);
      else        check_quiet($sformatf("rst_restart_c%0d", c));
    end
    a_if.ch_data = DATA;

    // DWELL=1, mask 1010: alternate 1,3 every cycle
    b_if.ch_mask = 4'b1010; b_if.en = 1'b1; b_if.mode = 1'b1;
    tick();
    check_val("b_entry_valid", 32'(b_if.y_valid), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check_val($sformatf("b_c%0d_valid", c), 32'(b_if.y_valid), 32'd1);
      check_val($sformatf("b_c%0d_ch", c), 32'(b_if.y_ch), (c % 2 == 1) ? 32'd1 : 32'd3);
      check_val($sformatf("b_c%0d_y", c), 32'(b_if.y), (c % 2 == 1) ? 32'h22 : 32'h44);
      check_val($sformatf("b_c%0d_done", c), 32'(b_if.scan_done), (c % 2 == 1) ? 32'd0 : 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Registered, parametrised N-channel multiplexer that generalises the gated 4:1 channel selector of the health-check datapath. It selects one of CHANNELS sensor words of WIDTH bits, either directly from a select input (manual mode) or by autonomously round-robin scanning the channels enabled in a mask, holding each for a programmable dwell time. It sits between the per-sensor capture registers and the shared threshold/compare stage, presenting one tagged sample per valid pulse.

## Interface
- WIDTH, 8: bits per channel word.
- CHANNELS, 4: number of input channels, ≥ 2.
- SEL_W, 2: select/tag width, equal to $clog2(CHANNELS).
- DWELL, 4: cycles spent on each channel in auto mode, ≥ 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; replaces the old E gate.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  SEL_W  manual channel select.
- ch_mask  in  CHANNELS  auto-scan channel enables; bit i = channel i.
- ch_data  in  CHANNELS*WIDTH  flattened inputs; channel i is ch_data[i*WIDTH +: WIDTH].
- y  out  WIDTH  registered selected word.
- y_ch  out  SEL_W  channel index of y.
- y_valid  out  1  one-cycle qualifier for y/y_ch.
- scan_done  out  1  one-cycle pulse marking the end of an auto round.

## Operation
- Reset: y=0, y_ch=0, y_valid=0, scan_done=0, state=S_MAN, ptr=0, cnt=0.
- States: S_MAN (mode=0) and S_SCAN (mode=1). Transitions are evaluated every cycle from mode, independent of en.
- Entry into S_SCAN from S_MAN: ptr ← lowest set bit of ch_mask (0 if mask is zero), cnt ← 0, and no sample that cycle.
- Entry into S_MAN: immediate. ptr and cnt are don't-care until the next S_SCAN entry.
- en=0, either state: y ← 0, y_valid ← 0, scan_done ← 0. ptr and cnt are frozen. y_ch holds its value.
- S_MAN, en=1:
  - sel < CHANNELS: y ← ch_data[sel], y_ch ← sel, y_valid ← 1.
  - sel ≥ CHANNELS (non-power-of-2 CHANNELS): y ← 0, y_valid ← 0.
  - ch_mask is ignored. scan_done=0.
- S_SCAN, en=1:
  - cnt < DWELL-1: cnt ← cnt+1, y_valid ← 0.
  - cnt = DWELL-1 (sample cycle): cnt ← 0, and ptr ← next set mask bit strictly after ptr, circular.
    - If ch_mask[ptr]=1: y ← ch_data[ptr], y_ch ← ptr, y_valid ← 1. scan_done ← 1 if ptr is the highest set bit of ch_mask.
    - If ch_mask[ptr]=0 (mask changed mid-dwell): no valid and no scan_done; ptr still advances.
  - ch_mask = 0: cnt and ptr hold, y_valid=0, scan_done=0, y ← 0.
  - Single enabled channel: ptr stays on it; every sample asserts y_valid and scan_done.
- Outputs during non-sample S_SCAN cycles: y and y_ch hold their last values; y_valid=0.

## Timing
- Manual latency is 1 cycle: sel/ch_data at edge k appear on y at edge k+1.
- Auto, mask nonzero, en steady: first y_valid is DWELL cycles after the first S_SCAN cycle. Subsequent samples follow at a period of DWELL cycles per enabled channel.
- The sample cycle captures ch_data as present at that edge; no earlier capture.
- scan_done is coincident with the y_valid of the last channel in a round, never standalone except as noted above (never, in fact).
- rst mid-dwell or mid-round: all state returns to reset values at that edge and takes priority over en and mode. Behaviour after release follows the state-entry rules.
- mode toggling in the same cycle as a sample: the S_MAN rule applies (mode is sampled first).

## Test plan
- Reset then manual, WIDTH=8, ch_data={8'h44,8'h33,8'h22,8'h11}, en=1, sel=2 -> next cycle y=8'h33, y_ch=2, y_valid=1. Then en=0 -> y=0, y_valid=0.
- Auto, DWELL=4, ch_mask=4'b1111 -> y_valid on cycles 4,8,12,16 with y_ch=0,1,2,3. scan_done only at cycle 16, then the pattern repeats from channel 0.
- Auto, ch_mask=4'b1010, DWELL=1 -> y_ch alternates 1,3,1,3 every cycle, with scan_done on every y_ch=3 sample.
- Auto, ch_mask=0 for 10 cycles -> y_valid=0, scan_done=0 throughout. Setting mask=4'b0100 then gives the first valid with y_ch=2 after DWELL cycles.
- Auto, en dropped for 3 cycles at cnt=2 of channel 1 -> no valid during the stall, and the channel 1 sample arrives exactly 3 cycles late with y_ch=1.
- rst asserted at cnt=2 on channel 2 with mode=1 held -> outputs 0. After release, the scan restarts at the lowest enabled channel with a full DWELL.
